// File: rtl/interrupt_controller_pkg.sv
// ============================================================================
// interrupt_controller_pkg : shared FSM state encoding and source-count default
// Revision: 1.0
// ============================================================================
`default_nettype none

package interrupt_controller_pkg;

    localparam int C_NUM_IRQ_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_t;

endpackage

`default_nettype wire

// File: rtl/interrupt_controller_prienc.sv
// ============================================================================
// PriorityEncoder : returns the lowest set index, or all ones when none is set
// Revision: 1.0
// ============================================================================
`default_nettype none

module PriorityEncoder #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 3
) (
    input  logic [IN_WIDTH-1:0]  i_vec,
    output logic [OUT_WIDTH-1:0] o_idx
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_idx = '1;
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = OUT_WIDTH'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// interrupt_controller : latches/masks IRQ sources and runs an ACK/EOI handshake
// Optional: INTC_EDGE_TRIGGER_EN selects edge-triggered pending (default: level)
// Revision: 1.0
// ============================================================================
`default_nettype none

module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_IRQ  = C_NUM_IRQ_DEFAULT,
    parameter int ID_WIDTH = $clog2(NUM_IRQ)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_IRQ-1:0]  IRQ_IN,
    input  logic                MASK_WE,
    input  logic [NUM_IRQ-1:0]  MASK_IN,
    output logic [NUM_IRQ-1:0]  MASK_OUT,
    output logic [NUM_IRQ-1:0]  PENDING,
    output logic                IRQ_REQ,
    output logic [ID_WIDTH-1:0] IRQ_ID,
    input  logic                IRQ_ACK,
    input  logic                EOI,
    output logic                IN_SERVICE
);

    intc_state_t         r_state;
    logic [NUM_IRQ-1:0]  r_mask;
    logic [NUM_IRQ-1:0]  r_pending;
    logic                r_req;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_insvc;

    logic [NUM_IRQ-1:0]  w_elig;
    logic [ID_WIDTH-1:0] w_enc;

    assign w_elig = r_pending & ~r_mask;

    PriorityEncoder #(
        .IN_WIDTH  (NUM_IRQ),
        .OUT_WIDTH (ID_WIDTH)
    ) u_prienc (
        .i_vec (w_elig),
        .o_idx (w_enc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mask <= '1;
        end else if (MASK_WE) begin
            r_mask <= MASK_IN;
        end
    end

`ifdef INTC_EDGE_TRIGGER_EN
    localparam logic [NUM_IRQ-1:0] c_ONE = NUM_IRQ'(1);

    logic [NUM_IRQ-1:0] r_sample;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_clr;

    assign w_rise = IRQ_IN & ~r_sample;
    assign w_clr  = (r_state == ST_REQUEST && IRQ_ACK) ? (c_ONE << r_id) : '0;

    // A fresh edge on the bit being acknowledged must survive its clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sample  <= '0;
            r_pending <= '0;
        end else begin
            r_sample  <= IRQ_IN;
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending <= '0;
        end else begin
            r_pending <= IRQ_IN;
        end
    end
`endif

    // Once a request is latched it is never withdrawn or re-selected.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_id    <= '0;
            r_insvc <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_elig != '0) begin
                        r_id    <= w_enc;
                        r_req   <= 1'b1;
                        r_state <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (IRQ_ACK) begin
                        r_req   <= 1'b0;
                        r_insvc <= 1'b1;
                        r_state <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (EOI) begin
                        r_insvc <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign MASK_OUT   = r_mask;
    assign PENDING    = r_pending;
    assign IRQ_REQ    = r_req;
    assign IRQ_ID     = r_id;
    assign IN_SERVICE = r_insvc;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// tb_interrupt_controller : directed + randomized check against a bench model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

    localparam int N  = 8;
    localparam int IW = 3;
`ifdef INTC_EDGE_TRIGGER_EN
    localparam bit c_LEVEL = 1'b0;
`else
    localparam bit c_LEVEL = 1'b1;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [N-1:0]  IRQ_IN = '0;
    logic          MASK_WE = 1'b0;
    logic [N-1:0]  MASK_IN = '0;
    logic [N-1:0]  MASK_OUT;
    logic [N-1:0]  PENDING;
    logic          IRQ_REQ;
    logic [IW-1:0] IRQ_ID;
    logic          IRQ_ACK = 1'b0;
    logic          EOI = 1'b0;
    logic          IN_SERVICE;

    int checks   = 0;
    int failures = 0;

    interrupt_controller #(.NUM_IRQ(N), .ID_WIDTH(IW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IRQ_IN     (IRQ_IN),
        .MASK_WE    (MASK_WE),
        .MASK_IN    (MASK_IN),
        .MASK_OUT   (MASK_OUT),
        .PENDING    (PENDING),
        .IRQ_REQ    (IRQ_REQ),
        .IRQ_ID     (IRQ_ID),
        .IRQ_ACK    (IRQ_ACK),
        .EOI        (EOI),
        .IN_SERVICE (IN_SERVICE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = nothing outstanding, 1 = offered to CPU, 2 = accepted by CPU
    int           m_phase = 0;
    int           m_id    = 0;
    logic [N-1:0] m_mask  = '1;
    logic [N-1:0] m_pend  = '0;
    logic [N-1:0] m_prev  = '0;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge CLK) begin
        logic [N-1:0] elig;
        logic [N-1:0] clr;
        if (RST) begin
            m_phase = 0; m_id = 0; m_mask = '1; m_pend = '0; m_prev = '0;
        end else begin
            elig = m_pend & ~m_mask;
            clr  = '0;
            if (m_phase == 0 && elig != 0) begin
                m_id = lowest(elig);
                m_phase = 1;
            end else if (m_phase == 1 && IRQ_ACK) begin
                m_phase = 2;
                clr[m_id] = 1'b1;
            end else if (m_phase == 2 && EOI) begin
                m_phase = 0;
            end
            if (c_LEVEL) m_pend = IRQ_IN;
            else         m_pend = (m_pend & ~clr) | (IRQ_IN & ~m_prev);
            m_prev = IRQ_IN;
            if (MASK_WE) m_mask = MASK_IN;
        end
    end

    always @(negedge CLK) begin
        chk("m_req",   {31'd0, IRQ_REQ},    {31'd0, m_phase == 1});
        chk("m_insvc", {31'd0, IN_SERVICE}, {31'd0, m_phase == 2});
        chk("m_id",    {29'd0, IRQ_ID},     m_id);
        chk("m_mask",  {24'd0, MASK_OUT},   {24'd0, m_mask});
        chk("m_pend",  {24'd0, PENDING},    {24'd0, m_pend});
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick(); tick();
        RST = 1'b0;
        chk("rst_mask", {24'd0, MASK_OUT}, 32'hFF);
        chk("rst_pend", {24'd0, PENDING}, 32'h0);
        chk("rst_req", {31'd0, IRQ_REQ}, 32'd0);
        chk("rst_id", {29'd0, IRQ_ID}, 32'd0);
        chk("rst_insvc", {31'd0, IN_SERVICE}, 32'd0);

        MASK_WE = 1'b1; MASK_IN = 8'h00; tick(); MASK_WE = 1'b0;
        chk("mask_wr", {24'd0, MASK_OUT}, 32'h00);

        // single source, full handshake
        IRQ_IN = 8'h20; tick(); IRQ_IN = 8'h00;
        chk("p5_pend", {31'd0, PENDING[5]}, 32'd1);
        chk("p5_req_early", {31'd0, IRQ_REQ}, 32'd0);
        tick();
        chk("p5_req", {31'd0, IRQ_REQ}, 32'd1);
        chk("p5_id", {29'd0, IRQ_ID}, 32'd5);
        IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        chk("p5_ack_req", {31'd0, IRQ_REQ}, 32'd0);
        chk("p5_ack_svc", {31'd0, IN_SERVICE}, 32'd1);
        EOI = 1'b1; tick(); EOI = 1'b0;
        chk("p5_eoi_svc", {31'd0, IN_SERVICE}, 32'd0);
        tick();
        chk("p5_idle", {31'd0, IRQ_REQ}, 32'd0);

        // two simultaneous sources: lower index first
        IRQ_IN = 8'h28; tick(); tick();
        chk("pr_id3", {29'd0, IRQ_ID}, 32'd3);
        IRQ_IN = 8'h20; IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        EOI = 1'b1; tick(); EOI = 1'b0;
        chk("pr_eoi_req", {31'd0, IRQ_REQ}, 32'd0);
        tick();
        chk("pr_req5", {31'd0, IRQ_REQ}, 32'd1);
        chk("pr_id5", {29'd0, IRQ_ID}, 32'd5);
        IRQ_IN = 8'h00; IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        EOI = 1'b1; tick(); EOI = 1'b0; tick();

        // masked source stays pending, then fires once unmasked
        MASK_WE = 1'b1; MASK_IN = 8'h08; tick(); MASK_WE = 1'b0;
        IRQ_IN = 8'h08; tick(); tick();
        chk("mk_req", {31'd0, IRQ_REQ}, 32'd0);
        chk("mk_pend", {31'd0, PENDING[3]}, 32'd1);
        MASK_WE = 1'b1; MASK_IN = 8'h00; tick(); MASK_WE = 1'b0;
        chk("mk_req_k", {31'd0, IRQ_REQ}, 32'd0);
        tick();
        chk("mk_req_k1", {31'd0, IRQ_REQ}, 32'd1);
        chk("mk_id", {29'd0, IRQ_ID}, 32'd3);
        IRQ_IN = 8'h00; IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        EOI = 1'b1; tick(); EOI = 1'b0; tick();

        // no preemption
        IRQ_IN = 8'h10; tick(); tick();
        IRQ_IN = 8'h12; tick();
        chk("np_id_req", {29'd0, IRQ_ID}, 32'd4);
        IRQ_IN = 8'h02; IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        chk("np_id_svc", {29'd0, IRQ_ID}, 32'd4);
        EOI = 1'b1; tick(); EOI = 1'b0; tick();
        chk("np_req1", {31'd0, IRQ_REQ}, 32'd1);
        chk("np_id1", {29'd0, IRQ_ID}, 32'd1);

        // ACK and EOI together: ACK wins, EOI dropped
        IRQ_IN = 8'h00; IRQ_ACK = 1'b1; EOI = 1'b1; tick(); IRQ_ACK = 1'b0; EOI = 1'b0;
        chk("ae_svc", {31'd0, IN_SERVICE}, 32'd1);
        tick();
        chk("ae_svc_hold", {31'd0, IN_SERVICE}, 32'd1);
        EOI = 1'b1; tick();
        chk("ae_eoi", {31'd0, IN_SERVICE}, 32'd0);
        tick(); EOI = 1'b0;
        chk("stray_eoi_req", {31'd0, IRQ_REQ}, 32'd0);
        chk("stray_eoi_svc", {31'd0, IN_SERVICE}, 32'd0);

        // source held through EOI
        IRQ_IN = 8'h04; tick(); tick();
        chk("hd_id", {29'd0, IRQ_ID}, 32'd2);
        IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        EOI = 1'b1; tick(); EOI = 1'b0;
        chk("hd_eoi_req", {31'd0, IRQ_REQ}, 32'd0);
        tick();
        chk("hd_rereq", {31'd0, IRQ_REQ}, {31'd0, c_LEVEL});
        chk("hd_reid", {29'd0, IRQ_ID}, 32'd2);
        IRQ_IN = 8'h00; IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        EOI = 1'b1; tick(); EOI = 1'b0; tick();

        // reset mid-service
        IRQ_IN = 8'h40; tick(); IRQ_IN = 8'h00; tick();
        IRQ_ACK = 1'b1; tick(); IRQ_ACK = 1'b0;
        chk("rs_svc", {31'd0, IN_SERVICE}, 32'd1);
        RST = 1'b1; EOI = 1'b1; tick(); RST = 1'b0; EOI = 1'b0;
        chk("rs_mask", {24'd0, MASK_OUT}, 32'hFF);
        chk("rs_pend", {24'd0, PENDING}, 32'h0);
        chk("rs_req", {31'd0, IRQ_REQ}, 32'd0);
        chk("rs_id", {29'd0, IRQ_ID}, 32'd0);
        chk("rs_svc0", {31'd0, IN_SERVICE}, 32'd0);

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            IRQ_IN  = ($urandom_range(0, 3) == 0) ? N'($urandom) & N'($urandom) : IRQ_IN;
            MASK_WE = ($urandom_range(0, 15) == 0);
            MASK_IN = N'($urandom) & N'($urandom) & N'($urandom);
            IRQ_ACK = ($urandom_range(0, 2) == 0);
            EOI     = ($urandom_range(0, 2) == 0);
            RST     = ($urandom_range(0, 499) == 0);
            tick();
        end
        RST = 1'b0; IRQ_ACK = 1'b0; EOI = 1'b0; MASK_WE = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
